// File: rtl/prm_edge_mask_engine.sv
// prm_edge_mask_engine: scans a loadable sum-of-products cube table once per query and returns a per-edge collision mask
// Ports: clk/rst_n clock and async active-low reset;
//   cube_we/cube_addr/cube_en/cube_edge/cube_care/cube_val write one table entry, wr_err pulses when a write is dropped;
//   q_valid/q_ready/q_cfg/num_cubes accept a query; r_valid/r_ready/r_mask/r_early return its result; busy = not idle.
module prm_edge_mask_engine #(
  parameter int IN_W    = 15,
  parameter int N_EDGE  = 8,
  parameter int N_CUBE  = 128,
  parameter int CUBE_AW = $clog2(N_CUBE),
  parameter int EDGE_W  = (N_EDGE > 1) ? $clog2(N_EDGE) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cube_we,
  input  logic [CUBE_AW-1:0] cube_addr,
  input  logic               cube_en,
  input  logic [EDGE_W-1:0]  cube_edge,
  input  logic [IN_W-1:0]    cube_care,
  input  logic [IN_W-1:0]    cube_val,
  output logic               wr_err,
  input  logic [CUBE_AW:0]   num_cubes,
  input  logic               q_valid,
  output logic               q_ready,
  input  logic [IN_W-1:0]    q_cfg,
  output logic               r_valid,
  input  logic               r_ready,
  output logic [N_EDGE-1:0]  r_mask,
  output logic               r_early,
  output logic               busy
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_nxt;
  logic [N_CUBE-1:0] tab_en;
  logic [EDGE_W-1:0] tab_edge [N_CUBE];
  logic [IN_W-1:0] tab_care [N_CUBE];
  logic [IN_W-1:0] tab_val [N_CUBE];
  logic [IN_W-1:0] cfg;
  logic [CUBE_AW:0] count, num_clamp;
  logic [CUBE_AW-1:0] idx;
  logic [N_EDGE-1:0] mask, mask_nxt;
  logic early, hit, last, all_set, edge_bad, wr_ok;
  assign num_clamp = (num_cubes > (CUBE_AW+1)'(N_CUBE)) ? (CUBE_AW+1)'(N_CUBE) : num_cubes;
  assign hit = tab_en[idx] & ~|((cfg ^ tab_val[idx]) & tab_care[idx]);
  assign mask_nxt = mask | (hit ? N_EDGE'(1) << tab_edge[idx] : '0);
  assign last = {1'b0, idx} == count - 1'b1;
  assign all_set = &mask_nxt;
  // only reachable when N_EDGE is not a power of two
  assign edge_bad = {1'b0, cube_edge} >= (EDGE_W+1)'(N_EDGE);
  assign wr_ok = cube_we & (state != SCAN) & ~edge_bad;
  assign q_ready = state == IDLE;
  assign r_valid = state == DONE;
  assign busy = state != IDLE;
  assign r_mask = mask;
  assign r_early = early;
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (q_valid) state_nxt = (num_clamp == '0) ? DONE : SCAN;
      SCAN: if (last || all_set) state_nxt = DONE;
      DONE: if (r_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cfg <= '0;
      count <= '0;
      idx <= '0;
      mask <= '0;
      early <= 1'b0;
      wr_err <= 1'b0;
      tab_en <= '0;
    end else begin
      state <= state_nxt;
      wr_err <= cube_we & ((state == SCAN) | edge_bad);
      if (wr_ok) tab_en[cube_addr] <= cube_en;
      if (state == IDLE && q_valid) begin
        cfg <= q_cfg;
        count <= num_clamp;
        idx <= '0;
        mask <= '0;
        early <= 1'b0;
      end else if (state == SCAN) begin
        mask <= mask_nxt;
        idx <= idx + 1'b1;
        // early only when saturation beats the natural end of the table
        early <= all_set & ~last;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      tab_edge[cube_addr] <= cube_edge;
      tab_care[cube_addr] <= cube_care;
      tab_val[cube_addr] <= cube_val;
    end
  end
endmodule

// File: tb/tb_prm_edge_mask_engine.sv
// tb_prm_edge_mask_engine: table-driven and scoreboarded checks of prm_edge_mask_engine
module tb_prm_edge_mask_engine;
  logic clk = 1'b0;
  logic rst_n;
  logic cube_we, cube_en, wr_err, q_valid, q_ready, r_valid, r_ready, r_early, busy;
  logic [6:0] cube_addr;
  logic [2:0] cube_edge;
  logic [14:0] cube_care, cube_val, q_cfg;
  logic [7:0] num_cubes, r_mask;
  typedef struct {logic [7:0] mask; logic early; int lat;} exp_t;
  typedef struct {logic [14:0] cfg; logic [7:0] num; logic [7:0] mask; logic early; int lat;} vec_t;
  exp_t sb[$];
  vec_t vt[10];
  int tests = 0, fails = 0;
  prm_edge_mask_engine dut (
    .clk(clk), .rst_n(rst_n), .cube_we(cube_we), .cube_addr(cube_addr), .cube_en(cube_en),
    .cube_edge(cube_edge), .cube_care(cube_care), .cube_val(cube_val), .wr_err(wr_err),
    .num_cubes(num_cubes), .q_valid(q_valid), .q_ready(q_ready), .q_cfg(q_cfg),
    .r_valid(r_valid), .r_ready(r_ready), .r_mask(r_mask), .r_early(r_early), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic write_cube(input logic [6:0] a, input logic en, input logic [2:0] e, input logic [14:0] c, input logic [14:0] v);
    @(negedge clk);
    cube_we = 1'b1; cube_addr = a; cube_en = en; cube_edge = e; cube_care = c; cube_val = v;
    @(negedge clk);
    cube_we = 1'b0;
    check("wr_err_idle", wr_err, 0);
  endtask
  task automatic start_q(input logic [14:0] c, input logic [7:0] n, input logic [7:0] m, input logic e, input int l);
    @(negedge clk);
    q_cfg = c; num_cubes = n; q_valid = 1'b1;
    check("q_ready_accept", q_ready, 1);
    sb.push_back('{m, e, l});
    @(negedge clk);
    q_valid = 1'b0;
  endtask
  task automatic collect(input int lat0, input string nm, input int hold);
    int lat = lat0;
    exp_t e;
    while (!r_valid && lat < 400) begin
      @(negedge clk);
      lat++;
    end
    check({nm, "_valid"}, r_valid, 1);
    if (sb.size() == 0) begin
      fails++;
      $display("FAIL %s_scoreboard: got empty expected entry", nm);
    end else begin
      e = sb.pop_front();
      check({nm, "_lat"}, lat, e.lat);
      check({nm, "_mask"}, r_mask, e.mask);
      check({nm, "_early"}, r_early, e.early);
      for (int i = 0; i < hold; i++) begin
        q_valid = 1'b1; num_cubes = 8'd0;
        @(negedge clk);
        check({nm, "_hold_mask"}, {r_valid, q_ready, r_mask}, {2'b10, e.mask});
      end
    end
    q_valid = 1'b0;
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    check({nm, "_idle"}, {q_ready, r_valid, busy}, 3'b100);
  endtask
  task automatic run_vec(input int i);
    start_q(vt[i].cfg, vt[i].num, vt[i].mask, vt[i].early, vt[i].lat);
    collect(1, $sformatf("vec%0d", i), 0);
  endtask
  initial begin
    vt[0] = '{15'h4000, 8'd1, 8'h08, 1'b0, 2};
    vt[1] = '{15'h3FFF, 8'd1, 8'h00, 1'b0, 2};
    vt[2] = '{15'h0001, 8'd6, 8'h08, 1'b0, 7};
    vt[3] = '{15'h4001, 8'd6, 8'h08, 1'b0, 7};
    vt[4] = '{15'h4000, 8'd200, 8'h08, 1'b0, 129};
    vt[5] = '{15'h7FFF, 8'd0, 8'h00, 1'b0, 1};
    vt[6] = '{15'h0000, 8'd20, 8'hFF, 1'b1, 9};
    vt[7] = '{15'h1234, 8'd8, 8'hFF, 1'b0, 9};
    vt[8] = '{15'h7FFF, 8'd3, 8'h07, 1'b0, 4};
    vt[9] = '{15'h0ABC, 8'd128, 8'hFF, 1'b1, 9};
    rst_n = 1'b0; cube_we = 1'b0; cube_addr = '0; cube_en = 1'b0; cube_edge = '0;
    cube_care = '0; cube_val = '0; q_valid = 1'b0; q_cfg = '0; num_cubes = '0; r_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs", {q_ready, r_valid, busy, wr_err, r_early, r_mask}, {5'b10000, 8'h00});
    start_q(15'h7FFF, 8'd4, 8'h00, 1'b0, 5);
    collect(1, "empty_table", 0);
    write_cube(7'd0, 1'b1, 3'd3, 15'h4000, 15'h4000);
    write_cube(7'd5, 1'b1, 3'd3, 15'h0001, 15'h0001);
    for (int i = 0; i < 6; i++) run_vec(i);
    for (int i = 0; i < 8; i++) write_cube(7'(i), 1'b1, 3'(i), 15'h0000, 15'h0000);
    for (int i = 6; i < 10; i++) run_vec(i);
    start_q(15'h0000, 8'd5, 8'h1F, 1'b0, 6);
    check("busy_scan", busy, 1);
    cube_we = 1'b1; cube_addr = 7'd0; cube_en = 1'b0; cube_edge = 3'd0;
    @(negedge clk);
    cube_we = 1'b0;
    check("wr_err_scan", wr_err, 1);
    @(negedge clk);
    check("wr_err_pulse_end", wr_err, 0);
    collect(3, "scan_write", 0);
    start_q(15'h0000, 8'd5, 8'h1F, 1'b0, 6);
    collect(1, "after_drop", 0);
    start_q(15'h7FFF, 8'd3, 8'h07, 1'b0, 4);
    collect(1, "hold", 10);
    @(negedge clk);
    q_cfg = 15'h0000; num_cubes = 8'd20; q_valid = 1'b1;
    @(negedge clk);
    q_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_outputs", {r_valid, busy, q_ready, r_early, r_mask}, {4'b0010, 8'h00});
    @(negedge clk);
    rst_n = 1'b1;
    start_q(15'h1234, 8'd20, 8'h00, 1'b0, 21);
    collect(1, "post_reset", 0);
    start_q(15'h7FFF, 8'd8, 8'h00, 1'b0, 9);
    collect(1, "post_reset2", 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
